// File: rtl/win_lose_banner_draw_pkg.sv
// Shared types and constants for the win/lose banner drawer and its rectangle hit helper.
package win_lose_pkg;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned EXT_W   = COORD_W + 1;
  localparam int unsigned CNT_W   = 8;

  localparam logic BANNER_SEL_WIN  = 1'b0;
  localparam logic BANNER_SEL_LOSE = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHOW_WIN  = 2'd1,
    SHOW_LOSE = 2'd2
  } banner_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  // Signed coordinates (top-left) widen by sign bit, scan coordinates by zero.
  function automatic logic [EXT_W-1:0] sext(input logic [COORD_W-1:0] v);
    return {v[COORD_W-1], v};
  endfunction

  function automatic logic [EXT_W-1:0] zext(input logic [COORD_W-1:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/win_lose_banner_draw_rect_hit_reg.sv
// Signed rectangle hit test with registered hit flag and bitmap-relative offsets (1-cycle latency).
module rect_hit_reg
  import win_lose_pkg::*;
#(
  parameter int unsigned OBJECT_WIDTH_X  = 128,
  parameter int unsigned OBJECT_HEIGHT_Y = 32
) (
  input  logic   clk,
  input  logic   reset,
  input  coord_t pixel_i,
  input  coord_t top_left_i,
  input  logic   enable_i,
  output logic   hit_o,
  output coord_t offset_o
);

  logic signed [EXT_W-1:0] px_s;
  logic signed [EXT_W-1:0] py_s;
  logic signed [EXT_W-1:0] tlx_s;
  logic signed [EXT_W-1:0] tly_s;
  logic signed [EXT_W-1:0] rx_s;
  logic signed [EXT_W-1:0] by_s;
  logic                    inside_c;

  logic   hit_d;
  logic   hit_q;
  coord_t off_d;
  coord_t off_q;

  assign px_s  = $signed(zext(pixel_i.x));
  assign py_s  = $signed(zext(pixel_i.y));
  assign tlx_s = $signed(sext(top_left_i.x));
  assign tly_s = $signed(sext(top_left_i.y));
  assign rx_s  = tlx_s + $signed(EXT_W'(OBJECT_WIDTH_X));
  assign by_s  = tly_s + $signed(EXT_W'(OBJECT_HEIGHT_Y));

  // Right and bottom edges are exclusive.
  assign inside_c = (px_s >= tlx_s) && (px_s < rx_s) &&
                    (py_s >= tly_s) && (py_s < by_s);

  // Low bits of the 12-bit difference equal the wrapped 11-bit difference.
  always_comb begin
    hit_d = 1'b0;
    off_d = '0;
    if (inside_c) begin
      hit_d   = enable_i;
      off_d.x = pixel_i.x - top_left_i.x;
      off_d.y = pixel_i.y - top_left_i.y;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q <= 1'b0;
      off_q <= '0;
    end else begin
      hit_q <= hit_d;
      off_q <= off_d;
    end
  end

  assign hit_o    = hit_q;
  assign offset_o = off_q;

endmodule

// File: rtl/win_lose_banner_draw.sv
// Win/lose banner drawer: game-over FSM, optional frame blink (WIN_LOSE_BANNER_BLINK_EN),
// and registered draw request / bitmap offsets for the banner ROM and drawing mux.
module win_lose_banner_draw
  import win_lose_pkg::*;
#(
  parameter int unsigned OBJECT_WIDTH_X  = 128,
  parameter int unsigned OBJECT_HEIGHT_Y = 32,
  parameter int unsigned BLINK_FRAMES    = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic [COORD_W-1:0] pixelX,
  input  logic [COORD_W-1:0] pixelY,
  input  logic [COORD_W-1:0] topLeftX,
  input  logic [COORD_W-1:0] topLeftY,
  input  logic               playerWin,
  input  logic               playerLose,
  input  logic               restart,
  output logic               drawingRequest,
  output logic [COORD_W-1:0] offsetX,
  output logic [COORD_W-1:0] offsetY,
  output logic               bannerSel,
  output logic               bannerActive
);

  banner_state_t state_q;
  banner_state_t state_d;
  logic          banner_sel_q;
  logic          banner_sel_d;
  logic          banner_active_q;
  logic          banner_active_d;
  logic          visible_c;
  logic          draw_en_c;

  coord_t pix_c;
  coord_t top_left_c;
  coord_t off_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      banner_sel_q    <= BANNER_SEL_WIN;
      banner_active_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      banner_sel_q    <= banner_sel_d;
      banner_active_q <= banner_active_d;
    end
  end

  // Restart beats win/lose; lose beats win; SHOW_* states are sticky.
  always_comb begin
    state_d         = state_q;
    banner_sel_d    = BANNER_SEL_WIN;
    banner_active_d = 1'b0;
    if (restart) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (playerLose) begin
            state_d = SHOW_LOSE;
          end else if (playerWin) begin
            state_d = SHOW_WIN;
          end
        end
        SHOW_WIN, SHOW_LOSE: ;
        default: state_d = IDLE;
      endcase
    end
    banner_active_d = (state_d != IDLE);
    banner_sel_d    = (state_d == SHOW_LOSE) ? BANNER_SEL_LOSE : BANNER_SEL_WIN;
  end

`ifdef WIN_LOSE_BANNER_BLINK_EN
  logic [CNT_W-1:0] frame_cnt_q;
  logic [CNT_W-1:0] frame_cnt_d;
  logic             visible_q;
  logic             visible_d;

  // Counter restarts in IDLE and on entry to a SHOW_* state.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    visible_d   = visible_q;
    if ((state_q == IDLE) || (state_d == IDLE)) begin
      frame_cnt_d = '0;
      visible_d   = 1'b1;
    end else if (startOfFrame) begin
      if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        visible_d   = ~visible_q;
      end else begin
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
      visible_q   <= 1'b1;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      visible_q   <= visible_d;
    end
  end

  assign visible_c = visible_q;
`else
  assign visible_c = 1'b1;
`endif

  // A pixel sampled together with restart is never drawn.
  assign draw_en_c = banner_active_q && visible_c && !restart;

  assign pix_c.x      = pixelX;
  assign pix_c.y      = pixelY;
  assign top_left_c.x = topLeftX;
  assign top_left_c.y = topLeftY;

  rect_hit_reg #(
    .OBJECT_WIDTH_X (OBJECT_WIDTH_X),
    .OBJECT_HEIGHT_Y(OBJECT_HEIGHT_Y)
  ) u_rect_hit_reg (
    .clk       (clk),
    .reset     (reset),
    .pixel_i   (pix_c),
    .top_left_i(top_left_c),
    .enable_i  (draw_en_c),
    .hit_o     (drawingRequest),
    .offset_o  (off_c)
  );

  assign offsetX      = off_c.x;
  assign offsetY      = off_c.y;
  assign bannerSel    = banner_sel_q;
  assign bannerActive = banner_active_q;

endmodule

// File: tb/tb_win_lose_banner_draw.sv
// Bench for win_lose_banner_draw: directed vector table, blink/restart sequences, random vs model.
module tb_win_lose_banner_draw;

  localparam int BLINK = 3;
  localparam int W     = 128;
  localparam int H     = 32;

  logic        clk = 1'b0;
  logic        reset, startOfFrame, playerWin, playerLose, restart;
  logic [10:0] pixelX, pixelY, topLeftX, topLeftY;
  logic        drawingRequest, bannerSel, bannerActive;
  logic [10:0] offsetX, offsetY;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  win_lose_banner_draw #(
    .OBJECT_WIDTH_X (W),
    .OBJECT_HEIGHT_Y(H),
    .BLINK_FRAMES   (BLINK)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .startOfFrame  (startOfFrame),
    .pixelX        (pixelX),
    .pixelY        (pixelY),
    .topLeftX      (topLeftX),
    .topLeftY      (topLeftY),
    .playerWin     (playerWin),
    .playerLose    (playerLose),
    .restart       (restart),
    .drawingRequest(drawingRequest),
    .offsetX       (offsetX),
    .offsetY       (offsetY),
    .bannerSel     (bannerSel),
    .bannerActive  (bannerActive)
  );

  typedef struct {
    logic win, lose, rst, sof;
    int   px, py, tlx, tly;
    logic dr;
    int   ox, oy;
    logic sel, act;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: game mode (0 none, 1 win, 2 lose) and frames seen since entry.
  int m_mode = 0;
  int m_sofs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rs, input logic w, input logic l, input logic r,
                       input logic s, input int px, input int py, input int tlx, input int tly);
    reset        = rs;
    playerWin    = w;
    playerLose   = l;
    restart      = r;
    startOfFrame = s;
    pixelX       = 11'(px);
    pixelY       = 11'(py);
    topLeftX     = 11'(tlx);
    topLeftY     = 11'(tly);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic dr, input int ox, input int oy,
                           input logic sel, input logic act);
    chk({tag, ".dr"},  32'(drawingRequest), 32'(dr));
    chk({tag, ".ox"},  32'(offsetX), 32'(ox));
    chk({tag, ".oy"},  32'(offsetY), 32'(oy));
    chk({tag, ".sel"}, 32'(bannerSel), 32'(sel));
    chk({tag, ".act"}, 32'(bannerActive), 32'(act));
  endtask

  function automatic logic model_visible(input int sofs);
`ifdef WIN_LOSE_BANNER_BLINK_EN
    return ((sofs / BLINK) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  initial begin
    logic exp_blink[7];
    logic e_in, e_dr, e_sel, e_act;
    int   e_ox, e_oy, old_mode;
    int   px, py, tlx, tly;
    logic rs, w, l, r, s;

    // Directed table: each row is applied for one cycle, outputs checked after the edge.
    tbl.push_back('{0,0,0,0,  40, 70,  32, 64, 0,  8,  6, 0, 0});
    tbl.push_back('{1,0,0,0,  40, 70,  32, 64, 0,  8,  6, 0, 1});
    tbl.push_back('{0,0,0,0,  40, 70,  32, 64, 1,  8,  6, 0, 1});
    tbl.push_back('{0,0,0,0, 160, 70,  32, 64, 0,  0,  0, 0, 1});
    tbl.push_back('{0,0,0,0, 159, 95,  32, 64, 1,127, 31, 0, 1});
    tbl.push_back('{0,0,0,0, 159, 96,  32, 64, 0,  0,  0, 0, 1});
    tbl.push_back('{0,0,0,0,  31, 70,  32, 64, 0,  0,  0, 0, 1});
    tbl.push_back('{0,0,1,0,  40, 70,  32, 64, 0,  8,  6, 0, 0});
    tbl.push_back('{1,1,0,0,  40, 70,  32, 64, 0,  8,  6, 1, 1});
    tbl.push_back('{1,0,0,0,  40, 70,  32, 64, 1,  8,  6, 1, 1});
    tbl.push_back('{0,0,0,0,   0,  0, -16, -8, 1, 16,  8, 1, 1});
    tbl.push_back('{0,0,0,0, 112,  0, -16, -8, 0,  0,  0, 1, 1});
    tbl.push_back('{0,0,0,0, 111, 23, -16, -8, 1,127, 31, 1, 1});
    tbl.push_back('{0,0,0,0,   0, 24, -16, -8, 0,  0,  0, 1, 1});

    drive(1, 0, 0, 0, 0, 40, 70, 32, 64);
    tick();
    tick();
    check_all("reset", 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      drive(0, tbl[i].win, tbl[i].lose, tbl[i].rst, tbl[i].sof,
            tbl[i].px, tbl[i].py, tbl[i].tlx, tbl[i].tly);
      tick();
      check_all($sformatf("vec%0d", i), tbl[i].dr, tbl[i].ox, tbl[i].oy, tbl[i].sel, tbl[i].act);
    end

    // Blink: frame k is the span after k startOfFrame pulses.
`ifdef WIN_LOSE_BANNER_BLINK_EN
    exp_blink = '{1, 1, 1, 0, 0, 0, 1};
`else
    exp_blink = '{1, 1, 1, 1, 1, 1, 1};
`endif
    drive(0, 0, 0, 1, 0, 40, 70, 32, 64);
    tick();
    drive(0, 1, 0, 0, 0, 40, 70, 32, 64);
    tick();
    for (int k = 0; k < 7; k++) begin
      drive(0, 0, 0, 0, 0, 40, 70, 32, 64);
      tick();
      chk($sformatf("blink_frame%0d", k), 32'(drawingRequest), 32'(exp_blink[k]));
      if (k < 6) begin
        drive(0, 0, 0, 0, 1, 40, 70, 32, 64);
        tick();
      end
    end

    // One more frame so the counter is mid-period, then restart with lose and startOfFrame.
    drive(0, 0, 0, 0, 1, 40, 70, 32, 64);
    tick();
    drive(0, 0, 1, 1, 1, 40, 70, 32, 64);
    tick();
    check_all("restart_mix", 0, 8, 6, 0, 0);
    drive(0, 0, 0, 0, 0, 40, 70, 32, 64);
    tick();
    check_all("restart_idle", 0, 8, 6, 0, 0);
    drive(0, 1, 0, 0, 0, 40, 70, 32, 64);
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 0, 1, 40, 70, 32, 64);
      tick();
      drive(0, 0, 0, 0, 0, 40, 70, 32, 64);
      tick();
      chk($sformatf("cnt_cleared%0d", k), 32'(drawingRequest), 32'(1));
    end

    // Reset while drawing: nothing residual next cycle.
    drive(1, 0, 0, 0, 0, 40, 70, 32, 64);
    tick();
    check_all("reset_mid", 0, 0, 0, 0, 0);

    // Random traffic against the model, starting from reset.
    m_mode = 0;
    m_sofs = 0;
    for (int n = 0; n < 3000; n++) begin
      rs  = (n == 0) || ($urandom_range(0, 299) == 0);
      w   = ($urandom_range(0, 39) == 0);
      l   = ($urandom_range(0, 39) == 0);
      r   = ($urandom_range(0, 59) == 0);
      s   = ($urandom_range(0, 7) == 0);
      tlx = int'($urandom_range(0, 900)) - 200;
      tly = int'($urandom_range(0, 600)) - 100;
      px  = tlx + int'($urandom_range(0, 170)) - 20;
      py  = tly + int'($urandom_range(0, 50)) - 10;
      if (px < 0) px = 0;
      if (px > 799) px = 799;
      if (py < 0) py = 0;
      if (py > 599) py = 599;
      drive(rs, w, l, r, s, px, py, tlx, tly);

      e_in = (px >= tlx) && (px < tlx + W) && (py >= tly) && (py < tly + H);
      if (rs) begin
        e_dr = 0; e_ox = 0; e_oy = 0;
        m_mode = 0;
        m_sofs = 0;
      end else begin
        e_dr = e_in && (m_mode != 0) && model_visible(m_sofs) && !r;
        e_ox = e_in ? px - tlx : 0;
        e_oy = e_in ? py - tly : 0;
        old_mode = m_mode;
        if (r) m_mode = 0;
        else if (m_mode == 0) m_mode = l ? 2 : (w ? 1 : 0);
        if (m_mode == 0 || old_mode == 0) m_sofs = 0;
        else if (s) m_sofs++;
      end
      e_act = (m_mode != 0);
      e_sel = (m_mode == 2);

      tick();
      check_all($sformatf("rnd%0d", n), e_dr, e_ox, e_oy, e_sel, e_act);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
